// File: rtl/aes_mix_columns_unit.sv
`default_nettype none
// ============================================================================
//  Module   : aes_mix_columns_unit
//  Purpose  : AES round-datapath stage. Applies MixColumns (encrypt) or
//             InvMixColumns (decrypt) to a 128-bit state and holds the
//             result in a single output register behind a valid/ready
//             handshake. One clock of latency, full throughput.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in    1   clock, rising edge
//    rst        in    1   asynchronous reset, active-high
//    in_valid   in    1   data_in / inv valid this cycle
//    in_ready   out   1   unit can accept input this cycle
//    inv        in    1   0 = MixColumns, 1 = InvMixColumns (sampled with data_in)
//    data_in    in  128   input state
//    out_valid  out   1   data_out holds a result
//    out_ready  in    1   downstream accepts data_out this cycle
//    data_out   out 128   transformed state
// ----------------------------------------------------------------------------
//  Configuration
//    AES_MIXCOL_INV_EN  defined   : inverse datapath built, inv selects transform
//                       undefined : forward path only, inv is ignored
// ----------------------------------------------------------------------------
//  State layout: column c = data[32c+31:32c]; row r of column c is
//  data[32c+8r+7 : 32c+8r] (row 0 is the least significant byte).
// ============================================================================
module aes_mix_columns_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  // --------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial 0x11B
  // --------------------------------------------------------------------------
  function automatic logic [7:0] f_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] f_mul2(input logic [7:0] x);
    return f_xtime(x);
  endfunction

  function automatic logic [7:0] f_mul3(input logic [7:0] x);
    return f_xtime(x) ^ x;
  endfunction

`ifdef AES_MIXCOL_INV_EN
  // Inverse coefficients built from the x2/x4/x8 chain of a single operand.
  function automatic logic [7:0] f_mul9(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = f_xtime(x);
    x4 = f_xtime(x2);
    x8 = f_xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] f_mulb(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = f_xtime(x);
    x4 = f_xtime(x2);
    x8 = f_xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] f_muld(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = f_xtime(x);
    x4 = f_xtime(x2);
    x8 = f_xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] f_mule(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = f_xtime(x);
    x4 = f_xtime(x2);
    x8 = f_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Combinational column transforms
  // --------------------------------------------------------------------------
  logic [127:0] w_mix;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0]  w_a0, w_a1, w_a2, w_a3;
    logic [31:0] w_fwd;

    assign w_a0 = data_in[32*c +  0 +: 8];
    assign w_a1 = data_in[32*c +  8 +: 8];
    assign w_a2 = data_in[32*c + 16 +: 8];
    assign w_a3 = data_in[32*c + 24 +: 8];

    // Packed MSB-first, so row 3 is the leftmost byte.
    assign w_fwd = {
      f_mul3(w_a0) ^ w_a1         ^ w_a2         ^ f_mul2(w_a3),
      w_a0         ^ w_a1         ^ f_mul2(w_a2) ^ f_mul3(w_a3),
      w_a0         ^ f_mul2(w_a1) ^ f_mul3(w_a2) ^ w_a3,
      f_mul2(w_a0) ^ f_mul3(w_a1) ^ w_a2         ^ w_a3
    };

`ifdef AES_MIXCOL_INV_EN
    logic [31:0] w_inv;

    assign w_inv = {
      f_mulb(w_a0) ^ f_muld(w_a1) ^ f_mul9(w_a2) ^ f_mule(w_a3),
      f_muld(w_a0) ^ f_mul9(w_a1) ^ f_mule(w_a2) ^ f_mulb(w_a3),
      f_mul9(w_a0) ^ f_mule(w_a1) ^ f_mulb(w_a2) ^ f_muld(w_a3),
      f_mule(w_a0) ^ f_mulb(w_a1) ^ f_muld(w_a2) ^ f_mul9(w_a3)
    };

    assign w_mix[32*c +: 32] = inv ? w_inv : w_fwd;
`else
    assign w_mix[32*c +: 32] = w_fwd;
`endif
  end

`ifndef AES_MIXCOL_INV_EN
  // Port kept for drop-in compatibility; the forward-only build ignores it.
  logic w_unused_inv;
  assign w_unused_inv = inv;
`endif

  // --------------------------------------------------------------------------
  // Output register and handshake
  // --------------------------------------------------------------------------
  logic         r_out_valid;
  logic [127:0] r_data_out;
  logic         w_in_ready;
  logic         w_in_fire;

  // The register can take a new result when empty or when it is being
  // drained in the same cycle.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_in_fire  = in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_data_out  <= 128'h0;
    end else begin
      if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_data_out  <= w_mix;
      end else if (out_ready) begin
        // Drained with nothing new behind it; data_out keeps its value.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_aes_mix_columns_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_mix_columns_unit
//  Purpose  : Directed self-checking bench for aes_mix_columns_unit using
//             known-answer vectors, fixed points, handshake stall and
//             asynchronous reset behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_mix_columns_unit;

  localparam logic [127:0] C_FWD_IN  = 128'h627a6f6644b109c82b18330a81c3b3e5;
  localparam logic [127:0] C_FWD_OUT = 128'h7b5b54657374566563746f725d53475d;
  localparam logic [127:0] C_INV_IN  = 128'h8dcab9dc035006bc8f57161e00cafd8d;
  localparam logic [127:0] C_INV_OUT = 128'hd635a667928b5eaeeec9cc3bc55f5777;
  localparam logic [127:0] C_ZERO    = 128'h0;
  localparam logic [127:0] C_ONES    = 128'h01010101010101010101010101010101;
  localparam logic [127:0] C_COL_IN  = 128'h000000000000000000000000455313db;
  localparam logic [127:0] C_COL_OUT = 128'h00000000000000000000000000bca14d8e;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         inv;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  int n_checks;
  int n_fail;

  aes_mix_columns_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inv       (inv),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one input for one edge with the output side draining, then
  // sample 1 time unit after the edge.
  task automatic xfer(input logic [127:0] d, input logic m);
    in_valid  = 1'b1;
    data_in   = d;
    inv       = m;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    inv       = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    #2;
    chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
    chk("reset_data_out", data_out, C_ZERO);
    chk("reset_in_ready", {127'h0, in_ready}, 128'h1);
    @(negedge clk);
    rst = 1'b0;

    // Forward known-answer vector, one clock latency
    xfer(C_FWD_IN, 1'b0);
    chk("fwd_valid", {127'h0, out_valid}, 128'h1);
    chk("fwd_data", data_out, C_FWD_OUT);

    // Drain with no new input: valid drops, data holds
    @(posedge clk);
    #1;
    chk("drain_valid", {127'h0, out_valid}, 128'h0);
    chk("drain_hold", data_out, C_FWD_OUT);

    // Fixed points and FIPS-197 column
    xfer(C_ZERO, 1'b0);
    chk("fwd_zero", data_out, C_ZERO);
    xfer(C_ONES, 1'b0);
    chk("fwd_ones", data_out, C_ONES);
    xfer(C_COL_IN, 1'b0);
    chk("fwd_fips_col", data_out, C_COL_OUT);
    xfer(C_ONES, 1'b1);
    chk("inv_ones", data_out, C_ONES);
    xfer(C_ZERO, 1'b1);
    chk("inv_zero", data_out, C_ZERO);

`ifdef AES_MIXCOL_INV_EN
    xfer(C_INV_IN, 1'b1);
    chk("inv_data", data_out, C_INV_OUT);
    // Round trip: inverse of a forward result restores the original
    xfer(C_FWD_OUT, 1'b1);
    chk("round_trip", data_out, C_FWD_IN);
`else
    // Forward-only build: inv must be ignored
    xfer(C_FWD_IN, 1'b1);
    chk("inv_ignored", data_out, C_FWD_OUT);
`endif

    // Back-to-back transfers at full throughput
    in_valid  = 1'b1;
    out_ready = 1'b1;
    inv       = 1'b0;
    data_in   = C_FWD_IN;
    @(posedge clk);
    #1;
    chk("b2b_first", data_out, C_FWD_OUT);
    chk("b2b_ready", {127'h0, in_ready}, 128'h1);
    data_in = C_COL_IN;
    @(posedge clk);
    #1;
    chk("b2b_second", data_out, C_COL_OUT);
    chk("b2b_valid", {127'h0, out_valid}, 128'h1);

    // Stall for 3 cycles with a pending input; inv toggling must not matter
    out_ready = 1'b0;
    data_in   = C_ONES;
    for (int i = 0; i < 3; i++) begin
      inv = i[0];
      #1;
      chk("stall_in_ready", {127'h0, in_ready}, 128'h0);
      @(posedge clk);
      #1;
      chk("stall_data", data_out, C_COL_OUT);
      chk("stall_valid", {127'h0, out_valid}, 128'h1);
    end

    // Release: input accepted the same cycle, result at the next edge
    inv       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {127'h0, in_ready}, 128'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("release_data", data_out, C_ONES);
    chk("release_valid", {127'h0, out_valid}, 128'h1);

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {127'h0, out_valid}, 128'h0);
    chk("async_rst_data", data_out, C_ZERO);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", {127'h0, out_valid}, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
